// File: rtl/xera4_video_pkg.sv
// Shared constants and types for the XERA4 640x480 scanout: timing, framebuffer geometry, RGB332 layout.
package xera4_video_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned SCALE = 4;
  localparam int unsigned FB_W  = H_ACTIVE / SCALE;
  localparam int unsigned FB_H  = V_ACTIVE / SCALE;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned PIX_W  = 8;

  localparam int unsigned RED_HI = 7;
  localparam int unsigned RED_LO = 5;
  localparam int unsigned GRN_HI = 4;
  localparam int unsigned GRN_LO = 2;
  localparam int unsigned BLU_HI = 1;
  localparam int unsigned BLU_LO = 0;

  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic frame_start;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/xera4_vga_timing.sv
// Raster counters with active/sync/frame-start decode and end-of-line/end-of-frame strobes.
module xera4_vga_timing
  import xera4_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = xera4_video_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = xera4_video_pkg::H_FP,
  parameter int unsigned H_SYNC   = xera4_video_pkg::H_SYNC,
  parameter int unsigned H_BP     = xera4_video_pkg::H_BP,
  parameter int unsigned V_ACTIVE = xera4_video_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = xera4_video_pkg::V_FP,
  parameter int unsigned V_SYNC   = xera4_video_pkg::V_SYNC,
  parameter int unsigned V_BP     = xera4_video_pkg::V_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output vid_ctl_t         o_ctl,
  output logic             o_eol,
  output logic             o_eof
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_eol;

  assign w_eol = (r_hcnt == H_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_eol) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + CNT_W'(1);
    end else begin
      r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_ctl             = CTL_IDLE;
    o_ctl.active      = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    o_ctl.hsync_n     = !((r_hcnt >= HS_BEG) && (r_hcnt <= HS_END));
    o_ctl.vsync_n     = !((r_vcnt >= VS_BEG) && (r_vcnt <= VS_END));
    o_ctl.frame_start = (r_hcnt == '0) && (r_vcnt == '0);
  end

  assign o_hcnt = r_hcnt;
  assign o_vcnt = r_vcnt;
  assign o_eol  = w_eol;
  assign o_eof  = w_eol && (r_vcnt == V_LAST);

endmodule

// File: rtl/xera4_video_scanout.sv
// Reads the 160x120 RGB332 framebuffer through the second VRAM port and emits a 4x-scaled 640x480 VGA stream.
module xera4_video_scanout
  import xera4_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = xera4_video_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = xera4_video_pkg::H_FP,
  parameter int unsigned H_SYNC   = xera4_video_pkg::H_SYNC,
  parameter int unsigned H_BP     = xera4_video_pkg::H_BP,
  parameter int unsigned V_ACTIVE = xera4_video_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = xera4_video_pkg::V_FP,
  parameter int unsigned V_SYNC   = xera4_video_pkg::V_SYNC,
  parameter int unsigned V_BP     = xera4_video_pkg::V_BP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] base_add,
  output logic [ADDR_W-1:0] vram_add,
  output logic              vram_re,
  input  logic [PIX_W-1:0]  vram_in,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE / SCALE);
  localparam logic [CNT_W-1:0]  V_ACT    = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0]  w_hcnt;
  logic [CNT_W-1:0]  w_vcnt;
  vid_ctl_t          w_ctl;
  logic              w_eol;
  logic              w_eof;
  logic              w_fetch;
  logic              w_row_adv;
  logic [ADDR_W-1:0] w_fetch_add;
  logic [ADDR_W-1:0] r_row_base;
  vid_ctl_t          r_ctl_d1;
  vid_ctl_t          r_ctl_d2;
  logic [PIX_W-1:0]  r_pix;

  xera4_vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_hcnt  (w_hcnt),
    .o_vcnt  (w_vcnt),
    .o_ctl   (w_ctl),
    .o_eol   (w_eol),
    .o_eof   (w_eof)
  );

  // One fetch per 4-pixel group; the row base steps by one framebuffer row every 4 lines.
  assign w_fetch     = w_ctl.active && (w_hcnt[1:0] == 2'b00);
  assign w_row_adv   = w_eol && (w_vcnt < V_ACT) && (w_vcnt[1:0] == 2'b11);
  assign w_fetch_add = r_row_base + ADDR_W'(w_hcnt[CNT_W-1:2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_base <= '0;
    end else if (w_eof) begin
      r_row_base <= base_add;
    end else if (w_row_adv) begin
      r_row_base <= r_row_base + ROW_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_add <= '0;
      vram_re  <= 1'b0;
    end else begin
      vram_re <= w_fetch;
      if (w_fetch) begin
        vram_add <= w_fetch_add;
      end
    end
  end

  // vram_re doubles as the stage-1 marker: the RAM data for that fetch is on vram_in now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix    <= '0;
      r_ctl_d1 <= CTL_IDLE;
      r_ctl_d2 <= CTL_IDLE;
    end else begin
      if (vram_re) begin
        r_pix <= vram_in;
      end
      r_ctl_d1 <= w_ctl;
      r_ctl_d2 <= r_ctl_d1;
    end
  end

  always_comb begin
    red         = '0;
    green       = '0;
    blue        = '0;
    if (r_ctl_d2.active) begin
      red   = r_pix[RED_HI:RED_LO];
      green = r_pix[GRN_HI:GRN_LO];
      blue  = r_pix[BLU_HI:BLU_LO];
    end
    hsync       = r_ctl_d2.hsync_n;
    vsync       = r_ctl_d2.vsync_n;
    blank       = !r_ctl_d2.active;
    frame_start = r_ctl_d2.frame_start;
  end

endmodule

// File: tb/tb_xera4_video_scanout.sv
// Directed bench: full-size instance for line-level timing, reduced-raster instance for multi-frame behaviour.
module tb_xera4_video_scanout;

  // Reduced raster keeps whole-frame scenarios short: 96 clocks/line, 24 lines/frame.
  localparam int SHA = 64, SHFP = 8, SHS = 12, SHBP = 12, SHT = 96;
  localparam int SVA = 16, SVFP = 2, SVS = 2, SVBP = 4, SVT = 24;
  localparam int SFR = SHT * SVT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] base_add;

  logic [14:0] s_add;
  logic        s_re;
  logic [7:0]  s_in;
  logic [2:0]  s_r, s_g;
  logic [1:0]  s_b;
  logic        s_hs, s_vs, s_bl, s_fs;

  logic [14:0] f_add;
  logic        f_re;
  logic [7:0]  f_in;
  logic [2:0]  f_r, f_g;
  logic [1:0]  f_b;
  logic        f_hs, f_vs, f_bl, f_fs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // VRAM models: read data is the low byte of the address being presented.
  assign s_in = s_add[7:0];
  assign f_in = f_add[7:0];

  xera4_video_scanout #(
    .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
    .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP)
  ) dut (
    .clk (clk), .rst_n (rst_n), .base_add (base_add),
    .vram_add (s_add), .vram_re (s_re), .vram_in (s_in),
    .red (s_r), .green (s_g), .blue (s_b),
    .hsync (s_hs), .vsync (s_vs), .blank (s_bl), .frame_start (s_fs)
  );

  xera4_video_scanout dut_full (
    .clk (clk), .rst_n (rst_n), .base_add (15'h0000),
    .vram_add (f_add), .vram_re (f_re), .vram_in (f_in),
    .red (f_r), .green (f_g), .blue (f_b),
    .hsync (f_hs), .vsync (f_vs), .blank (f_bl), .frame_start (f_fs)
  );

  function automatic logic [14:0] fetch_addr(int h, int v, int base, int fbw);
    return 15'(base + (v / 4) * fbw + h / 4);
  endfunction

  // Expected {rgb, hsync, vsync, blank, frame_start} at the pins for raster position pc.
  function automatic logic [11:0] model_out(int pc, int ha, int hfp, int hsw, int htot,
                                            int va, int vfp, int vsw, int vtot, int base);
    int h, v;
    logic act;
    logic [14:0] a;
    logic [7:0] pix;
    if (pc < 0) return 12'b0000_0000_1110;
    h   = pc % htot;
    v   = (pc / htot) % vtot;
    act = (h < ha) && (v < va);
    a   = fetch_addr(h, v, base, ha / 4);
    pix = act ? a[7:0] : 8'h00;
    return {pix, !((h >= ha + hfp) && (h < ha + hfp + hsw)),
            !((v >= va + vfp) && (v < va + vfp + vsw)), !act, (h == 0) && (v == 0)};
  endfunction

  task automatic do_reset(input logic [14:0] b);
    rst_n    = 1'b0;
    base_add = b;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs ncyc clocks on the reduced instance from a reset release, comparing all pins every clock.
  task automatic run_scaled(input string name, input int ncyc, input int chg_k,
                            input logic [14:0] chg_val, output int fs_seen);
    int fb[0:7];
    logic [14:0] held;
    logic [27:0] exp_v, act_v;
    int pcf, h, v;
    logic re;
    fb      = '{default: 0};
    held    = '0;
    fs_seen = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == chg_k) base_add = chg_val;
      if (k % SFR == SFR - 1) fb[k / SFR + 1] = int'(base_add);
      pcf = k - 1;
      h   = pcf % SHT;
      v   = (pcf / SHT) % SVT;
      re  = (h < SHA) && (v < SVA) && (h % 4 == 0);
      if (re) held = fetch_addr(h, v, fb[pcf / SFR], SHA / 4);
      exp_v = {held, re, model_out(k - 2, SHA, SHFP, SHS, SHT, SVA, SVFP, SVS, SVT,
                                   fb[(k - 2) / SFR])};
      act_v = {s_add, s_re, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s k=%0d {add,re,rgb,hs,vs,blank,fs} got=%h exp=%h", name, k, act_v, exp_v);
      end
      if (s_fs) fs_seen++;
    end
  endtask

  task automatic test_reset();
    logic [27:0] idle;
    idle     = {15'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n    = 1'b0;
    base_add = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_add, s_re, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs} !== idle) begin
      failures++;
      $display("FAIL reset_small got=%h exp=%h",
               {s_add, s_re, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs}, idle);
    end
    checks++;
    if ({f_add, f_re, f_r, f_g, f_b, f_hs, f_vs, f_bl, f_fs} !== idle) begin
      failures++;
      $display("FAIL reset_full got=%h exp=%h",
               {f_add, f_re, f_r, f_g, f_b, f_hs, f_vs, f_bl, f_fs}, idle);
    end
  endtask

  // Full 640x480 instance over lines 0-4: pixel pattern, fetches and hsync timing.
  task automatic test_full_scan();
    logic [14:0] held;
    logic [27:0] exp_v, act_v;
    int pcf, h, v, fall1, fall2, rise1;
    logic re, prev_hs;
    held = '0; fall1 = 0; fall2 = 0; rise1 = 0; prev_hs = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      pcf = k - 1;
      h   = pcf % 800;
      v   = pcf / 800;
      re  = (h < 640) && (v < 480) && (h % 4 == 0);
      if (re) held = fetch_addr(h, v, 0, 160);
      exp_v = {held, re, model_out(k - 2, 640, 16, 96, 800, 480, 10, 2, 525, 0)};
      act_v = {f_add, f_re, f_r, f_g, f_b, f_hs, f_vs, f_bl, f_fs};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL full_scan k=%0d got=%h exp=%h", k, act_v, exp_v);
      end
      if (k == 3201) begin
        checks++;
        if ({f_re, f_add} !== {1'b1, 15'd160}) begin
          failures++;
          $display("FAIL line4_first_fetch got re=%b add=%h exp re=1 add=00a0", f_re, f_add);
        end
      end
      if (prev_hs && !f_hs) begin
        if (fall1 == 0) fall1 = k;
        else if (fall2 == 0) fall2 = k;
      end
      if (!prev_hs && f_hs && rise1 == 0) rise1 = k;
      prev_hs = f_hs;
    end
    checks++;
    if (fall1 != 658) begin
      failures++;
      $display("FAIL hsync_first_fall got=%0d exp=658", fall1);
    end
    checks++;
    if (rise1 - fall1 != 96) begin
      failures++;
      $display("FAIL hsync_low_width got=%0d exp=96", rise1 - fall1);
    end
    checks++;
    if (fall2 - fall1 != 800) begin
      failures++;
      $display("FAIL hsync_period got=%0d exp=800", fall2 - fall1);
    end
  endtask

  // First frame after reset uses base 0; the next one wraps 0x7FF8.. through 0x0000.
  task automatic test_base_wrap();
    int fs;
    do_reset(15'h7FF8);
    run_scaled("base_wrap", 2 * SFR + 200, 0, 15'h0000, fs);
    checks++;
    if (fs != 3) begin
      failures++;
      $display("FAIL base_wrap_frame_starts got=%0d exp=3", fs);
    end
  endtask

  // base_add changes at line 8 of the second frame; only the third frame picks it up.
  task automatic test_midframe_base();
    int fs;
    do_reset(15'h0040);
    run_scaled("midframe_base", 3 * SFR + 100, SFR + 8 * SHT, 15'h1000, fs);
    checks++;
    if (fs != 4) begin
      failures++;
      $display("FAIL midframe_frame_starts got=%0d exp=4", fs);
    end
  endtask

  task automatic test_reset_midline();
    int fs;
    logic [27:0] idle;
    idle = {15'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset(15'h0100);
    run_scaled("pre_midline", 10 * SHT + 30, 0, 15'h0000, fs);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_add, s_re, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs} !== idle) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h",
               {s_add, s_re, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs}, idle);
    end
    repeat (2) @(negedge clk);
    base_add = 15'h2222;
    rst_n    = 1'b1;
    run_scaled("post_midline", 300, 0, 15'h0000, fs);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_base_wrap();
    test_midframe_base();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
